// File: rtl/au_op_sequencer.sv
// au_op_sequencer: expands one request into the arithmetic unit's load/execute/readback
// control-byte sequence and returns the read-back accumulator with P/N/ERR status.
module au_op_sequencer #(
    parameter int MUL_TIMEOUT   = 200,
    parameter int ADDSUB_CYCLES = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_signed,
    input  logic [15:0] req_acc,
    input  logic [7:0]  req_operand,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_result,
    output logic        resp_p,
    output logic        resp_n,
    output logic        resp_err,
    output logic [7:0]  au_data,
    output logic [7:0]  au_ctrl,
    input  logic [7:0]  au_result,
    input  logic [3:0]  au_flags
);
    localparam int CW = $clog2((MUL_TIMEOUT > ADDSUB_CYCLES ? MUL_TIMEOUT : ADDSUB_CYCLES) + 1);

    typedef enum logic [2:0] {IDLE, LDL, LDH, EXEC, DRAIN, RDL, RDH, RESP} state_t;

    state_t        state, nxt;
    logic [1:0]    rst_sync;
    logic          rst_ok;
    logic          go;
    logic [1:0]    op;
    logic          sgn;
    logic [15:0]   acc;
    logic [7:0]    opd;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept, busy, tmo, exec_done, first;
    logic [7:0]    ctrl_nxt, data_nxt;

    // reset asserts asynchronously but releases on a clock edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};

    assign rst_ok     = rst_sync[1];
    assign req_ready  = state == IDLE && !go;
    assign accept     = req_ready && req_valid;
    assign resp_valid = state == RESP;
    assign busy       = state inside {LDL, LDH, EXEC, DRAIN, RDL, RDH};
    assign tmo        = cnt == CW'(MUL_TIMEOUT - 1);
    assign exec_done  = op == 2'b11 ? (au_flags[1] || tmo) : cnt == CW'(ADDSUB_CYCLES - 1);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = go ? LDL : IDLE;
            LDL:     nxt = cnt[0] ? LDH : LDL;
            LDH:     nxt = cnt[0] ? (op == 2'b00 ? DRAIN : EXEC) : LDH;
            EXEC:    nxt = exec_done ? DRAIN : EXEC;
            DRAIN:   nxt = RDL;
            RDL:     nxt = cnt[0] ? RDH : RDL;
            RDH:     nxt = cnt[0] ? RESP : RDH;
            RESP:    nxt = resp_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
        cnt_nxt  = nxt == state ? cnt + CW'(1) : '0;
        first    = cnt_nxt == '0;
        ctrl_nxt = 8'h00;
        data_nxt = 8'h00;
        case (nxt)
            LDL:   begin ctrl_nxt = {sgn, 2'b00, 2'b10, 1'b1, first, 1'b0}; data_nxt = acc[7:0];  end
            LDH:   begin ctrl_nxt = {sgn, 2'b00, 2'b11, 1'b1, first, 1'b0}; data_nxt = acc[15:8]; end
            EXEC:  begin ctrl_nxt = {sgn, op, 2'b11, 3'b110};               data_nxt = opd;       end
            DRAIN: ctrl_nxt = {sgn, op, 5'b00000};
            RDL:   ctrl_nxt = {sgn, 2'b00, 2'b10, 3'b000};
            RDH:   ctrl_nxt = {sgn, 2'b00, 2'b11, 3'b000};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ok)
        if (!rst_ok) begin
            state       <= IDLE;
            cnt         <= '0;
            go          <= 1'b0;
            op          <= 2'b00;
            sgn         <= 1'b0;
            acc         <= 16'h0000;
            opd         <= 8'h00;
            au_ctrl     <= 8'h00;
            au_data     <= 8'h00;
            resp_result <= 16'h0000;
            resp_p      <= 1'b0;
            resp_n      <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_nxt;
            au_ctrl <= ctrl_nxt;
            au_data <= data_nxt;
            go      <= accept;
            if (accept) begin
                op       <= req_op;
                sgn      <= req_signed;
                acc      <= req_acc;
                opd      <= req_operand;
                resp_p   <= 1'b0;
                resp_n   <= 1'b0;
                resp_err <= 1'b0;
            end
            if (busy && au_flags[0]) resp_err <= 1'b1;
            // F arriving on the final allowed cycle still counts as completion
            if (state == EXEC && op == 2'b11 && tmo && !au_flags[1]) resp_err <= 1'b1;
            if (state == EXEC && exec_done) {resp_p, resp_n} <= au_flags[3:2];
            if (state == RDL && cnt[0]) resp_result[7:0] <= au_result;
            if (state == RDH && cnt[0]) resp_result[15:8] <= au_result;
            if (resp_valid && resp_ready) resp_err <= 1'b0;
        end
endmodule

// File: tb/tb_au_op_sequencer.sv
// tb_au_op_sequencer: scoreboard bench with a behavioural arithmetic-unit model on the au_* pins.
module tb_au_op_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic        req_signed = 1'b0;
    logic [15:0] req_acc = 16'h0000;
    logic [7:0]  req_operand = 8'h00;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_result;
    logic        resp_p, resp_n, resp_err;
    logic [7:0]  au_data, au_ctrl, au_result;
    logic [3:0]  au_flags;

    au_op_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_signed(req_signed),
        .req_acc(req_acc), .req_operand(req_operand),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_p(resp_p), .resp_n(resp_n), .resp_err(resp_err),
        .au_data(au_data), .au_ctrl(au_ctrl), .au_result(au_result), .au_flags(au_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        p, n, err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          nvec = 0;
    int          errs = 0;
    logic [7:0]  ld_seq [9] = '{8'h16, 8'h14, 8'h1E, 8'h1C, 8'h00, 8'h10, 8'h10, 8'h18, 8'h18};

    function automatic logic [15:0] alu(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
        return op == 2'b01 ? a + {8'h00, d} : op == 2'b10 ? a - {8'h00, d} :
               op == 2'b11 ? a * {8'h00, d} : a;
    endfunction

    // unit model: B loads from the LD bytes, EXEC writes op(B, data) back, reads return B
    logic [15:0] mb = 16'h0000, mr = 16'h0000, ar;
    int          ec = 0;
    int          f_at = 0;
    logic        m_err = 1'b0;
    logic        is_ld, is_exec;

    assign is_ld     = au_ctrl[2] && au_ctrl[6:5] == 2'b00 && au_ctrl[4];
    assign is_exec   = au_ctrl[2:1] == 2'b11 && au_ctrl[6:5] != 2'b00;
    assign ar        = alu(au_ctrl[6:5], mb, au_data);
    assign au_result = au_ctrl[4:3] == 2'b10 ? mr[7:0] : au_ctrl[4:3] == 2'b11 ? mr[15:8] : 8'h00;
    assign au_flags  = {is_exec && ar != 16'h0 && !ar[15], is_exec && ar[15],
                        is_exec && f_at != 0 && ec == f_at - 1, m_err};

    always @(posedge clk) begin
        if (is_ld && !au_ctrl[3]) begin mb[7:0]  <= au_data; mr[7:0]  <= au_data; end
        if (is_ld && au_ctrl[3])  begin mb[15:8] <= au_data; mr[15:8] <= au_data; end
        if (is_exec) mr <= ar;
        ec <= is_exec ? ec + 1 : (req_ready ? 0 : ec);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic txn(input logic [1:0] op, input logic sg, input logic [15:0] acc, input logic [7:0] opd,
                       input int lat, input logic xerr, input int err_at, input int hold);
        exp_t        e;
        int          n;
        logic [15:0] res;
        res = alu(op, acc, opd);
        @(negedge clk);
        req_op = op; req_signed = sg; req_acc = acc; req_operand = opd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check("accept_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        e.res = res; e.p = op != 0 && res != 0 && !res[15]; e.n = op != 0 && res[15];
        e.err = xerr; e.lat = lat;
        sb.push_back(e);
        n = 0;
        while (!resp_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
            m_err = n == err_at;
            if (op == 2'b00 && n <= 9) check("ld_ctrl", au_ctrl, ld_seq[n-1]);
            if (op == 2'b01 && !sg && (n == 5 || n == 21)) check("add_exec_ctrl", au_ctrl, 8'h3E);
        end
        m_err = 1'b0;
        e = sb.pop_front();
        check("latency", n, e.lat);
        check("result", resp_result, e.res);
        check("flag_p", resp_p, e.p);
        check("flag_n", resp_n, e.n);
        check("err", resp_err, e.err);
        if (op != 2'b00) check("exec_len", ec, e.lat - 10);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_op = 2'b01; req_acc = 16'hDEAD;
            check("hold_valid", resp_valid, 1);
            check("hold_result", resp_result, e.res);
            check("hold_err", resp_err, e.err);
            check("hold_busy", req_ready, 0);
        end
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("back_idle", req_ready, 1);
        check("resp_drop", resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_valid", resp_valid, 0);
        check("rst_ctrl", au_ctrl, 8'h00);
        check("rst_data", au_data, 8'h00);
        check("rst_result", resp_result, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);

        txn(2'b00, 1'b0, 16'h1234, 8'h00, 10, 1'b0, 0, 0);
        txn(2'b01, 1'b0, 16'h00FF, 8'h01, 27, 1'b0, 0, 0);
        txn(2'b10, 1'b1, 16'h0005, 8'h07, 27, 1'b0, 0, 0);
        f_at = 130;
        txn(2'b11, 1'b0, 16'h0003, 8'h05, 140, 1'b0, 0, 0);
        f_at = 200;
        txn(2'b11, 1'b0, 16'h0102, 8'h03, 210, 1'b0, 0, 0);
        f_at = 0;
        txn(2'b11, 1'b0, 16'h0003, 8'h05, 210, 1'b1, 0, 0);
        txn(2'b00, 1'b0, 16'hA5C3, 8'h00, 10, 1'b1, 3, 0);
        txn(2'b01, 1'b0, 16'h7FFF, 8'h02, 27, 1'b0, 0, 5);
        txn(2'b10, 1'b0, 16'h0100, 8'h01, 27, 1'b0, 0, 0);

        @(negedge clk);
        req_op = 2'b11; req_signed = 1'b0; req_acc = 16'h0011; req_operand = 8'h02; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mul_exec_ctrl", au_ctrl, 8'h7E);
        rst_n = 1'b0;
        #1;
        check("abort_ctrl", au_ctrl, 8'h00);
        check("abort_ready", req_ready, 1);
        check("abort_valid", resp_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        txn(2'b00, 1'b0, 16'h4321, 8'h00, 10, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule

// File: doc/au_op_sequencer.md
# au_op_sequencer

Transaction-level controller for the 16-bit arithmetic unit. It accepts one operation request at a time over a valid/ready handshake and expands it into the unit's control-byte sequence: load accumulator, execute, then read back. It monitors the unit's flags during execution and returns the 16-bit result with status over a second valid/ready handshake. It sits between a host/command interface and the arithmetic unit's `ui_in`/`uio_in`/`uo_out`/`uio_out` pins.

## Interface
Parameters:
- `MUL_TIMEOUT`, default 200: maximum EXEC cycles for MUL before it aborts with an error.
- `ADDSUB_CYCLES`, default 17: fixed EXEC length for ADD/SUB.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept; high only in IDLE.
- `req_op`  in  2  00 LOAD, 01 ADD, 10 SUB, 11 MUL.
- `req_signed`  in  1  two's-complement mode (drives control bit C).
- `req_acc`  in  16  initial accumulator value, written to register B.
- `req_operand`  in  8  operand byte presented on `au_data` during EXEC.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_result`  out  16  accumulator read back after the operation.
- `resp_p`, `resp_n`  out  1 each  P/N flags, latched on the last EXEC cycle (0 for LOAD).
- `resp_err`  out  1  unit ERR seen, or MUL timeout.
- `au_data`  out  8  to unit `ui_in`.
- `au_ctrl`  out  8  to unit `uio_in`: [7] C, [6:5] op, [4:3] reg select (00 A lo, 01 A hi, 10 B lo, 11 B hi), [2] RW, [1] S, [0] 0.
- `au_result`  in  8  from unit `uo_out`.
- `au_flags`  in  4  from unit: [3] P, [2] N, [1] F, [0] ERR.

## Operation
- States: IDLE, LDL, LDH, EXEC, DRAIN, RDL, RDH, RESP.
- IDLE: `req_ready`=1. On `req_valid`&`req_ready`, latch all request fields into holding registers and go to LDL. Requests are never accepted outside IDLE.
- LDL (2 cycles): `au_ctrl`={C,00,10,1,S,0} and `au_data`=acc[7:0].
  - S=1 in the first cycle and 0 in the second.
- LDH (2 cycles): same as LDL with reg=11 and `au_data`=acc[15:8].
- LOAD op skips EXEC and goes LDH→DRAIN.
- EXEC: `au_ctrl`={C,op,11,1,1,0} and `au_data`=operand.
  - ADD/SUB: exactly `ADDSUB_CYCLES` cycles.
  - MUL: lasts until `au_flags[1]` (F) is sampled high, inclusive of that cycle. If F never rises, EXEC ends after `MUL_TIMEOUT` cycles and sets the sticky error.
  - P/N are captured from `au_flags` in the last EXEC cycle.
- ERR: `au_flags[0]` high in any cycle from LDL through RDH sets a sticky error bit. The sequence still runs to completion.
- DRAIN (1 cycle): S=0, RW=0 and op held. This lets the unit's counter reset.
- RDL (2 cycles): `au_ctrl`={C,00,10,0,0,0}. `au_result` is sampled into result[7:0] at the end of the second cycle.
- RDH (2 cycles): same with reg=11, sampled into result[15:8].
- RESP: `resp_valid`=1 and response fields stable. On `resp_ready`, go to IDLE and clear the sticky error. `resp_valid` may be held indefinitely.
- C stays constant from LDL through RDH, because the unit flags any change of C while S is active.

## Timing
- Reset (asynchronous assert, synchronous deassert inside the block): state IDLE, all holding registers 0.
  - Outputs at reset: `req_ready`=1, `resp_valid`=0, `resp_*`=0, `au_ctrl`=8'h00, `au_data`=8'h00.
- Latency is measured from the accept edge (cycle 0) to `resp_valid` high:
  - ADD/SUB: 4 + `ADDSUB_CYCLES` + 1 + 4 + 1 = 27 cycles with defaults.
  - LOAD: 10 cycles.
  - MUL: 10 + N, where N is the number of EXEC cycles (N ≤ `MUL_TIMEOUT`).
- `au_ctrl`/`au_data` are registered outputs. They change only on clock edges, one cycle after the state entry decision.
- `resp_valid`&`resp_ready` in the cycle RESP is entered: IDLE (`req_ready`=1) on the next cycle. Back-to-back throughput is therefore latency + 1.
- `req_valid` while busy: ignored, and the request fields are not sampled.
- `rst_n` low mid-operation: immediate return to IDLE with `au_ctrl` at 0 (S=0). No response is issued for the aborted request.
- MUL: F and timeout expiring in the same cycle counts as success (no timeout error).

## Test plan
- Reset mid-EXEC of a MUL → next cycle `au_ctrl`=00, `req_ready`=1, `resp_valid`=0; then a new LOAD completes normally.
- LOAD acc=16'h1234 with `au_result` model returning B → `resp_valid` at cycle 10, `resp_result`=16'h1234, `resp_err`=0, `au_ctrl` sequence 0x16,0x14,0x1E,0x1C,0x00(DRAIN),0x10,0x10,0x18,0x18.
- ADD unsigned acc=16'h00FF operand=8'h01 → EXEC 17 cycles with `au_ctrl`=0x3E, `resp_valid` at cycle 27, `resp_result`=16'h0100, P/N as the flag model drives.
- MUL where model raises F after 130 EXEC cycles → `resp_valid` at cycle 140, `resp_err`=0; with F never raised → EXEC lasts 200 cycles and `resp_err`=1.
- `au_flags[0]` pulsed for 1 cycle during LDH → transaction completes, `resp_err`=1; the next transaction reports `resp_err`=0.
- `resp_ready` held low 5 cycles in RESP → `resp_valid` and fields stable, `req_valid` ignored; `resp_ready`=1 → IDLE next cycle, and a second request is accepted on that cycle.
